pergate_accum: RTL
==================

// Module: pergate_accum
// PURPOSE
//  Downstream of the per-gate compute units in a sum-check round. Captures the
//  3 evaluations (gate_out[2:0]) from each of ngates pergate_compute units.
//  Reduces them serially, one gate per cycle, into 3 running sums mod F_Q.
//  The sums are the round-polynomial evaluations passed to the transcript/verifier interface.
// PARAMETERS
//  ngates   4   number of pergate_compute units feeding this block (>=1)
//  nvals    3   evaluations per gate; fixed at 3 to match gate_out[2:0]
// PORTS
//  clk          in   1                    clock
//  rstb         in   1                    async active-low reset
//  en           in   1                    start pulse: capture gate_in, begin reduction
//  restart      in   1                    sync abort/clear; return to idle
//  accum        in   1                    sampled with en: 1 = add onto existing sums, 0 = start from 0
//  gate_in      in   [F_NBITS-1:0] x [ngates-1:0][2:0]   gate_out of each unit
//  ready        out  1                    idle and sums valid
//  ready_pulse  out  1                    one-cycle strobe when a reduction completes
//  sum          out  [F_NBITS-1:0] x [2:0]               running sums mod F_Q
// BEHAVIOUR
//  Reset (rstb=0, async): state=IDLE, idx=0, sum[*]=0, ready=1, ready_pulse=0, buffer=0.
//  States: IDLE, RUN. idx has clog2(ngates) bits (min 1).
//  IDLE, en=1, restart=0: latch all gate_in into buffer; sum[*]<=0 if accum=0, else hold.
//   Also idx<=0, ready<=0, state<=RUN.
//  RUN, each cycle: sum[j] <= modadd(sum[j], buf[idx][j]) for j=0..2 in parallel; idx<=idx+1.
//   At idx==ngates-1, that add completes; ready<=1, ready_pulse<=1, state<=IDLE.
//  Latency: en sampled at edge t -> ready and ready_pulse high after edge t+ngates.
//   ready_pulse is low on all other cycles.
//  ready_pulse is registered, not derived combinationally from ready.
//  en while RUN: ignored. The buffer is not overwritten and the sums are unaffected.
//  restart=1, any state: state<=IDLE, sum[*]<=0, idx<=0, ready<=1, ready_pulse<=0.
//   restart overrides en in the same cycle. A run aborted by restart never pulses.
//  modadd(a,b): t=a+b in F_NBITS+1 bits; result = (t >= F_Q) ? t-F_Q : t.
//   Inputs are canonical (< F_Q); output is always canonical.
//  gate_in is sampled only at the en edge; it may change freely during RUN.
//  ngates==1: RUN lasts exactly one cycle.
//  sum holds its value in IDLE. During RUN, sum shows partial totals; consumers must qualify with ready.
//  rstb asserted mid-RUN: immediate return to reset values; no ready_pulse.
// TESTING
//  1 reset, no stimulus -> ready=1, ready_pulse=0, sum={0,0,0}
//  2 ngates=4, gate_in[g]={g+1, 10*(g+1), 0}, en 1 cycle, accum=0
//    -> ready=0 for 4 cycles, then sum={10,100,0}, one ready_pulse
//  3 wrap: all gate_in[g][1]=F_Q-1, accum=0 -> sum[1]=F_Q-4; no value >= F_Q ever seen on sum
//  4 after test 2, en with accum=1, gate_in[g]={1,1,1}
//    -> sum={14,104,4} after 4 cycles; accum=0 repeat -> {4,4,4}
//  5 en pulsed again 2 cycles into RUN -> ignored, result per test 2
//    restart at cycle 2 of RUN -> next cycle ready=1, sum=0, no pulse
//    en+restart together -> stays IDLE
//  6 rstb low mid-RUN (between clk edges) -> outputs reset immediately
//    after release, en -> normal 4-cycle reduction

Source files
------------

// File: rtl/pergate_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : pergate_accum_if
//  Description : Control, gate-evaluation and result bundle for pergate_accum.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pergate_accum_if #(
    parameter int NGATES  = 4,
    parameter int NVALS   = 3,
    parameter int F_NBITS = 16
);
    logic                                          en;
    logic                                          restart;
    logic                                          accum;
    logic [NGATES-1:0][NVALS-1:0][F_NBITS-1:0]     gate_in;
    logic                                          ready;
    logic                                          ready_pulse;
    logic [NVALS-1:0][F_NBITS-1:0]                 sum;

    modport master (
        output en, restart, accum, gate_in,
        input  ready, ready_pulse, sum
    );

    modport slave (
        input  en, restart, accum, gate_in,
        output ready, ready_pulse, sum
    );
endinterface
`default_nettype wire

// File: rtl/pergate_accum.sv
`default_nettype none
// ============================================================================
//  Module      : pergate_accum
//  Description : Serial mod-F_Q reduction of per-gate evaluations into the
//                three round-polynomial sums, one gate per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pergate_accum #(
    parameter int NGATES  = 4,
    parameter int NVALS   = 3,
    parameter int F_NBITS = 16,
    parameter int F_Q     = 65521
) (
    input  wire logic        clk,
    input  wire logic        rstb,
    pergate_accum_if.slave   bus
);

    localparam int                 c_IDX_W  = (NGATES > 1) ? $clog2(NGATES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST   = c_IDX_W'(NGATES - 1);
    localparam logic [F_NBITS:0]   c_FQ_EXT = (F_NBITS + 1)'(F_Q);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                                     r_state;
    logic [c_IDX_W-1:0]                         r_idx;
    logic [NGATES-1:0][NVALS-1:0][F_NBITS-1:0]  r_buf;
    logic [NVALS-1:0][F_NBITS-1:0]              r_sum;
    logic                                       r_ready;
    logic                                       r_ready_pulse;

    state_t                                     w_state_nxt;
    logic [c_IDX_W-1:0]                         w_idx_nxt;
    logic [NGATES-1:0][NVALS-1:0][F_NBITS-1:0]  w_buf_nxt;
    logic [NVALS-1:0][F_NBITS-1:0]              w_sum_nxt;
    logic                                       w_ready_nxt;
    logic                                       w_pulse_nxt;
    logic [NVALS-1:0][F_NBITS-1:0]              w_add;

    // One modular adder per evaluation lane; the extra bit catches the carry
    // so a single conditional subtract keeps the result canonical.
    generate
        for (genvar j = 0; j < NVALS; j++) begin : g_lane
            logic [F_NBITS:0] w_t;
            assign w_t      = {1'b0, r_sum[j]} + {1'b0, r_buf[r_idx][j]};
            assign w_add[j] = (w_t >= c_FQ_EXT) ? F_NBITS'(w_t - c_FQ_EXT)
                                                : w_t[F_NBITS-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_buf         <= '0;
            r_sum         <= '0;
            r_ready       <= 1'b1;
            r_ready_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_buf         <= w_buf_nxt;
            r_sum         <= w_sum_nxt;
            r_ready       <= w_ready_nxt;
            r_ready_pulse <= w_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_buf_nxt   = r_buf;
        w_sum_nxt   = r_sum;
        w_ready_nxt = r_ready;
        w_pulse_nxt = 1'b0;

        if (bus.restart) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_sum_nxt   = '0;
            w_ready_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.en) begin
                        w_buf_nxt   = bus.gate_in;
                        if (!bus.accum) begin
                            w_sum_nxt = '0;
                        end
                        w_idx_nxt   = '0;
                        w_ready_nxt = 1'b0;
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_sum_nxt = w_add;
                    w_idx_nxt = r_idx + c_IDX_W'(1);
                    // Last gate: its add lands with the same edge that raises ready.
                    if (r_idx == c_LAST) begin
                        w_idx_nxt   = '0;
                        w_ready_nxt = 1'b1;
                        w_pulse_nxt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_ready_nxt = 1'b1;
                end
            endcase
        end
    end

    assign bus.ready       = r_ready;
    assign bus.ready_pulse = r_ready_pulse;
    assign bus.sum         = r_sum;

endmodule
`default_nettype wire
